pci_target_mem: RTL and testbench
=================================

Name: pci_target_mem

Overview:
- Simple PCI-style memory target that sits downstream of the initiator/arbiter/mux stage on the shared bus.
- Decodes address phases from GLOBAL_FRAME/GLOBAL_IRDY and the multiplexed AD/CBE lines.
- Claims transactions with DEVSEL, completes burst reads/writes against an internal word array with TRDY, and disconnects with STOP at the end of its window.
- Serves as the data sink/source that the SimpleInitiator instances talk to once granted.

Parameters:
BASE_ADDR, 32'h0000_1000, byte address of word 0; must be aligned to 4*DEPTH
DEPTH, 16, number of 32-bit words (power of 2, 2..256)
WAIT_STATES, 0, TRDY wait cycles inserted at the start of every data phase (0..7)

Ports:
clk  input  1  bus clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
GLOBAL_FRAME  input  1  bus FRAME#, active low
GLOBAL_IRDY  input  1  bus IRDY#, active low
AD_IN  input  32  address (address phase) / write data (data phase)
CBE  input  4  command (address phase) / byte enables, active low (data phase)
AD_OUT  output  32  read data
AD_OE  output  1  high = target drives AD (read data phases only)
DEVSEL  output  1  DEVSEL#, active low
TRDY  output  1  TRDY#, active low
STOP  output  1  STOP#, active low

Behaviour:
- Reset (rst=1 at an edge): state IDLE; TRDY=DEVSEL=STOP=1; AD_OE=0; AD_OUT=0; word index=0; wait counter=0; all memory words = 0. Reset mid-transaction aborts immediately, with no further memory write.
- Address phase: edge where GLOBAL_FRAME=0, previous-cycle GLOBAL_FRAME=1 and previous-cycle GLOBAL_IRDY=1 (bus was idle). Latch AD_IN and CBE.
- Hit: AD_IN[31:2] within [BASE_ADDR, BASE_ADDR+4*DEPTH), AD_IN[1:0] ignored, and CBE=4'b0110 (mem read) or 4'b0111 (mem write). Start index = (AD_IN-BASE_ADDR)>>2.
- States:
  - IDLE: on hit-write -> WDATA; on hit-read -> TURN; on miss -> BUSY.
  - BUSY: DEVSEL stays 1; return to IDLE on the first edge sampling GLOBAL_FRAME=1 and GLOBAL_IRDY=1.
  - TURN (reads only): one cycle, DEVSEL=0, TRDY=1, AD_OE=0 -> RDATA.
  - WDATA/RDATA: DEVSEL=0 from the cycle after the address phase until the transaction ends.
- Data phases:
  - Wait counter loads WAIT_STATES on entry to each data phase. TRDY=1 while counter>0, decrementing each cycle; TRDY=0 once it reaches 0.
  - RDATA: AD_OE=1 and AD_OUT=mem[index], valid the whole phase including waits.
  - Transfer = edge with GLOBAL_IRDY=0 and TRDY=0. Initiator waits (IRDY=1) hold TRDY=0 and all data; no transfer occurs.
  - Write transfer: mem[index] byte k <= AD_IN byte k when CBE[k]=0; CBE=4'hF writes nothing but still completes the phase.
  - After a transfer: index+1 and wait counter reloads.
  - Last phase: if GLOBAL_FRAME=1 at the transfer edge -> IDLE. DEVSEL, TRDY and AD_OE deassert on the next cycle.
- Window end: transfer at index DEPTH-1 with GLOBAL_FRAME=0 -> state DISC.
  - DISC: TRDY=1, STOP=0, DEVSEL=0, AD_OE=0; no further transfers.
  - Exit DISC to IDLE on the edge where GLOBAL_FRAME=1 and GLOBAL_IRDY=0 (initiator's final cycle); STOP and DEVSEL deassert the next cycle.
  - Index never wraps.
- Latency: DEVSEL low 1 cycle after the address phase. Earliest TRDY low: write 1 cycle after the address phase; read 2 cycles after, plus WAIT_STATES.
- GLOBAL_FRAME falling while the target is not IDLE and not returning to IDLE is ignored; only idle-bus address phases are decoded.

Test Plan:
- Single write/read (WAIT_STATES=0): write 32'hDEADBEEF to 0x1008 with CBE=0 -> DEVSEL=0 the cycle after addr, TRDY=0 same cycle, mem[2]=DEADBEEF. Read 0x1008 -> TURN cycle with AD_OE=0, then AD_OUT=DEADBEEF, AD_OE=1, TRDY=0.
- Byte enables: pre-load 0x11223344 at 0x1000, write 0xAABBCCDD with CBE=4'b1010 -> readback 0x11BB33DD.
- Burst + waits (WAIT_STATES=2): 4-word write burst from 0x1004 -> TRDY high 2 cycles per phase, mem[1..4] updated. Initiator IRDY=1 for 3 cycles mid-burst -> no extra write, data held.
- Disconnect: burst write starting at 0x103C (index 15), FRAME held low -> mem[15] written, then STOP=0, TRDY=1 until FRAME=1/IRDY=0; mem[0] unchanged.
- Miss/unsupported: address 0x2000, or command 4'b0010 at 0x1000 -> DEVSEL/TRDY/STOP stay 1 all transaction, memory unchanged; next valid access is claimed normally.
- Reset mid-burst: assert rst during the second data phase of a write -> next cycle TRDY=DEVSEL=STOP=1, AD_OE=0, all words read back 0.

Source files
------------

// File: rtl/pci_target_mem.sv
// PCI-style memory target: decodes idle-bus address phases, claims hits with
// DEVSEL, moves burst data against a word array with TRDY, and signals a
// disconnect with STOP at the end of its address window.
module pci_target_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        GLOBAL_FRAME,
  input  logic        GLOBAL_IRDY,
  input  logic [31:0] AD_IN,
  input  logic [3:0]  CBE,
  output logic [31:0] AD_OUT,
  output logic        AD_OE,
  output logic        DEVSEL,
  output logic        TRDY,
  output logic        STOP
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned WW = 3;
  localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);
  localparam logic [WW-1:0] WAIT_LOAD = WW'(WAIT_STATES);
  localparam logic [31:0]   SPAN      = 32'(4 * DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BUSY  = 3'd1;
  localparam logic [2:0] S_TURN  = 3'd2;
  localparam logic [2:0] S_WDATA = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;
  localparam logic [2:0] S_DISC  = 3'd5;

  localparam logic [3:0] CMD_MEM_RD = 4'b0110;
  localparam logic [3:0] CMD_MEM_WR = 4'b0111;

  logic [2:0]    state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic          prev_frame, prev_irdy;
  logic          wr_en_c;
  logic [31:0]   mem [DEPTH];

  logic [31:0] addr_word_c, offset_c;
  logic        addr_phase_c, in_range_c;

  // Address decode of the current AD/CBE lines
  always_comb begin
    addr_word_c  = {AD_IN[31:2], 2'b00};
    offset_c     = addr_word_c - BASE_ADDR;
    in_range_c   = (addr_word_c >= BASE_ADDR) && (offset_c < SPAN);
    addr_phase_c = !GLOBAL_FRAME && prev_frame && prev_irdy;
  end

  // Next-state, index and wait-counter logic
  always_comb begin
    state_n = state;
    idx_n   = idx;
    wcnt_n  = wcnt;
    wr_en_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (addr_phase_c) begin
          if (in_range_c && (CBE == CMD_MEM_WR)) begin
            state_n = S_WDATA;
            idx_n   = offset_c[IW+1:2];
            wcnt_n  = WAIT_LOAD;
          end else if (in_range_c && (CBE == CMD_MEM_RD)) begin
            state_n = S_TURN;
            idx_n   = offset_c[IW+1:2];
          end else begin
            state_n = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (GLOBAL_FRAME && GLOBAL_IRDY) state_n = S_IDLE;
      end
      S_TURN: begin
        state_n = S_RDATA;
        wcnt_n  = WAIT_LOAD;
      end
      S_WDATA, S_RDATA: begin
        if (wcnt != '0) begin
          wcnt_n = wcnt - WW'(1);
        end else if (!GLOBAL_IRDY) begin
          wr_en_c = (state == S_WDATA);
          wcnt_n  = WAIT_LOAD;
          if (GLOBAL_FRAME) begin
            state_n = S_IDLE;
          end else if (idx == LAST_IDX) begin
            state_n = S_DISC;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      S_DISC: begin
        if (GLOBAL_FRAME && !GLOBAL_IRDY) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, counters, bus history and registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      wcnt       <= '0;
      prev_frame <= 1'b1;
      prev_irdy  <= 1'b1;
      DEVSEL     <= 1'b1;
      TRDY       <= 1'b1;
      STOP       <= 1'b1;
      AD_OE      <= 1'b0;
      AD_OUT     <= '0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      wcnt       <= wcnt_n;
      prev_frame <= GLOBAL_FRAME;
      prev_irdy  <= GLOBAL_IRDY;
      DEVSEL     <= !((state_n == S_TURN) || (state_n == S_WDATA) ||
                      (state_n == S_RDATA) || (state_n == S_DISC));
      TRDY       <= !(((state_n == S_WDATA) || (state_n == S_RDATA)) && (wcnt_n == '0));
      STOP       <= !(state_n == S_DISC);
      AD_OE      <= (state_n == S_RDATA);
      AD_OUT     <= (state_n == S_RDATA) ? mem[idx_n] : '0;
    end
  end

  // Word array with per-byte write enables (CBE active low)
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (wr_en_c) begin
      for (int k = 0; k < 4; k++) begin
        if (!CBE[k]) mem[idx][8*k +: 8] <= AD_IN[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_pci_target_mem.sv
// Bench for pci_target_mem: two targets (0 and 2 wait states) on separate
// buses, driven by a transaction-level initiator and checked against a word
// array model.
module tb_pci_target_mem;

  logic        clk = 1'b0;
  logic        rst    [2];
  logic        frame  [2];
  logic        irdy   [2];
  logic [31:0] ad     [2];
  logic [3:0]  cbe    [2];
  logic [31:0] ad_out [2];
  logic        ad_oe  [2];
  logic        devsel [2];
  logic        trdy   [2];
  logic        stop   [2];

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [2][16];

  always #5 clk = ~clk;

  pci_target_mem #(.BASE_ADDR(32'h0000_1000), .DEPTH(16), .WAIT_STATES(0)) u_t0 (
    .clk(clk), .rst(rst[0]), .GLOBAL_FRAME(frame[0]), .GLOBAL_IRDY(irdy[0]),
    .AD_IN(ad[0]), .CBE(cbe[0]), .AD_OUT(ad_out[0]), .AD_OE(ad_oe[0]),
    .DEVSEL(devsel[0]), .TRDY(trdy[0]), .STOP(stop[0]));

  pci_target_mem #(.BASE_ADDR(32'h0000_1000), .DEPTH(16), .WAIT_STATES(2)) u_t1 (
    .clk(clk), .rst(rst[1]), .GLOBAL_FRAME(frame[1]), .GLOBAL_IRDY(irdy[1]),
    .AD_IN(ad[1]), .CBE(cbe[1]), .AD_OUT(ad_out[1]), .AD_OE(ad_oe[1]),
    .DEVSEL(devsel[1]), .TRDY(trdy[1]), .STOP(stop[1]));

  function automatic int ws(input int s);
    return (s == 0) ? 0 : 2;
  endfunction

  // Full transaction: address phase then n data phases; optional IRDY stall.
  task automatic burst(input int s, input int start, input bit wr, input int n,
                       input int stall_phase, input int stall_len, input bit rand_be,
                       input bit fixed, input logic [31:0] fd, input logic [3:0] fbe);
    logic [31:0] d;
    logic [3:0]  be;
    int phase, cycles, hi, stall_left, exp_hi;
    bit stall;
    @(negedge clk);
    frame[s] = 1'b0; irdy[s] = 1'b1;
    ad[s]  = 32'h0000_1000 + 32'(4 * start);
    cbe[s] = wr ? 4'b0111 : 4'b0110;
    @(negedge clk);
    checks++;
    if (devsel[s] !== 1'b0) begin
      errors++; $display("FAIL claim s%0d devsel got %b want 0", s, devsel[s]);
    end
    if (!wr) begin
      checks++;
      if (ad_oe[s] !== 1'b0 || trdy[s] !== 1'b1) begin
        errors++; $display("FAIL turn s%0d ad_oe/trdy got %b%b want 01", s, ad_oe[s], trdy[s]);
      end
    end else if (ws(s) == 0) begin
      checks++;
      if (trdy[s] !== 1'b0) begin
        errors++; $display("FAIL wr_latency s%0d trdy got %b want 0", s, trdy[s]);
      end
    end
    phase = 0; cycles = 0; hi = 0; stall_left = stall_len;
    d  = fixed ? fd : $urandom;
    be = fixed ? fbe : (rand_be ? 4'($urandom) : 4'h0);
    while (phase < n && cycles < 200) begin
      stall = (phase == stall_phase) && (stall_left > 0) && (trdy[s] === 1'b0);
      irdy[s]  = stall;
      frame[s] = (phase == n - 1);
      if (trdy[s] === 1'b1) hi++;
      if (stall) begin
        ad[s] = $urandom; cbe[s] = 4'h0; stall_left--;
        if (!wr) begin
          checks++;
          if (ad_out[s] !== ref_mem[s][start+phase]) begin
            errors++; $display("FAIL rd_hold s%0d idx %0d got %h want %h", s, start + phase,
                               ad_out[s], ref_mem[s][start+phase]);
          end
        end
      end else begin
        ad[s]  = wr ? d : $urandom;
        cbe[s] = wr ? be : 4'($urandom);
        if (trdy[s] === 1'b0) begin
          if (!wr) begin
            checks++;
            if (ad_out[s] !== ref_mem[s][start+phase] || ad_oe[s] !== 1'b1) begin
              errors++; $display("FAIL rd_data s%0d idx %0d got %h oe %b want %h oe 1", s,
                                 start + phase, ad_out[s], ad_oe[s], ref_mem[s][start+phase]);
            end
          end else begin
            for (int k = 0; k < 4; k++)
              if (!be[k]) ref_mem[s][start+phase][8*k +: 8] = d[8*k +: 8];
          end
          phase++;
          d  = $urandom;
          be = rand_be ? 4'($urandom) : 4'h0;
        end
      end
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 200) begin
      checks++; errors++;
      $display("FAIL timeout s%0d phases got %0d want %0d", s, phase, n);
    end
    exp_hi = n * ws(s) + (wr ? 0 : 1);
    checks++;
    if (hi != exp_hi) begin
      errors++; $display("FAIL trdy_waits s%0d got %0d want %0d", s, hi, exp_hi);
    end
    checks++;
    if (devsel[s] !== 1'b1 || trdy[s] !== 1'b1 || ad_oe[s] !== 1'b0 || stop[s] !== 1'b1) begin
      errors++; $display("FAIL release s%0d devsel/trdy/stop/oe got %b%b%b%b want 1110", s,
                         devsel[s], trdy[s], stop[s], ad_oe[s]);
    end
    frame[s] = 1'b1; irdy[s] = 1'b1;
  endtask

  task automatic read_all(input int s);
    burst(s, 0, 1'b0, 16, -1, 0, 1'b0, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; frame[s] = 1'b1; irdy[s] = 1'b1; ad[s] = '0; cbe[s] = 4'hF;
      for (int i = 0; i < 16; i++) ref_mem[s][i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (devsel[s] !== 1'b1 || trdy[s] !== 1'b1 || stop[s] !== 1'b1 ||
          ad_oe[s] !== 1'b0 || ad_out[s] !== 32'h0) begin
        errors++; $display("FAIL reset s%0d devsel/trdy/stop/oe %b%b%b%b ad_out %h want 1110 0",
                           s, devsel[s], trdy[s], stop[s], ad_oe[s], ad_out[s]);
      end
      rst[s] = 1'b0;
    end
  endtask

  task automatic test_single();
    burst(0, 2, 1'b1, 1, -1, 0, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'h0);
    burst(0, 2, 1'b0, 1, -1, 0, 1'b0, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic test_byte_enables();
    burst(0, 0, 1'b1, 1, -1, 0, 1'b0, 1'b1, 32'h1122_3344, 4'h0);
    burst(0, 0, 1'b1, 1, -1, 0, 1'b0, 1'b1, 32'hAABB_CCDD, 4'b1010);
    burst(0, 0, 1'b1, 1, -1, 0, 1'b0, 1'b1, 32'h5555_5555, 4'hF);
    burst(0, 0, 1'b0, 1, -1, 0, 1'b0, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic test_burst_waits();
    burst(1, 1, 1'b1, 4, 2, 3, 1'b0, 1'b0, 32'h0, 4'h0);
    burst(1, 1, 1'b0, 4, 1, 3, 1'b0, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic test_disconnect();
    logic [31:0] d;
    d = $urandom;
    @(negedge clk);
    frame[0] = 1'b0; irdy[0] = 1'b1; ad[0] = 32'h0000_103C; cbe[0] = 4'b0111;
    @(negedge clk);
    irdy[0] = 1'b0; ad[0] = d; cbe[0] = 4'h0;
    ref_mem[0][15] = d;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (stop[0] !== 1'b0 || trdy[0] !== 1'b1 || devsel[0] !== 1'b0 || ad_oe[0] !== 1'b0) begin
        errors++; $display("FAIL disc s0 cyc %0d stop/trdy/devsel/oe got %b%b%b%b want 0100", i,
                           stop[0], trdy[0], devsel[0], ad_oe[0]);
      end
      ad[0] = $urandom;
    end
    frame[0] = 1'b1; irdy[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (stop[0] !== 1'b1 || devsel[0] !== 1'b1) begin
      errors++; $display("FAIL disc_exit s0 stop/devsel got %b%b want 11", stop[0], devsel[0]);
    end
    frame[0] = 1'b1; irdy[0] = 1'b1;
    read_all(0);
  endtask

  task automatic miss(input int s, input logic [31:0] addr, input logic [3:0] cmd);
    @(negedge clk);
    frame[s] = 1'b0; irdy[s] = 1'b1; ad[s] = addr; cbe[s] = cmd;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (devsel[s] !== 1'b1 || trdy[s] !== 1'b1 || stop[s] !== 1'b1) begin
        errors++; $display("FAIL miss s%0d addr %h cyc %0d devsel/trdy/stop got %b%b%b want 111",
                           s, addr, i, devsel[s], trdy[s], stop[s]);
      end
      frame[s] = (i >= 2);
      irdy[s]  = (i >= 3);
      ad[s]    = $urandom;
      cbe[s]   = 4'h0;
    end
  endtask

  task automatic test_miss();
    miss(0, 32'h0000_2000, 4'b0111);
    miss(0, 32'h0000_1000, 4'b0010);
    miss(1, 32'h0000_0FFC, 4'b0110);
    burst(0, 3, 1'b1, 2, -1, 0, 1'b1, 1'b0, 32'h0, 4'h0);
    read_all(0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      int s, start, n, sp;
      bit wr;
      s     = int'($urandom_range(0, 1));
      start = int'($urandom_range(0, 15));
      n     = int'($urandom_range(1, 16 - start));
      wr    = 1'($urandom_range(0, 1));
      sp    = (n > 1) ? int'($urandom_range(0, n - 2)) : -1;
      burst(s, start, wr, n, sp, int'($urandom_range(0, 3)), 1'b1, 1'b0, 32'h0, 4'h0);
    end
    read_all(0);
    read_all(1);
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [31:0] d;
    d = $urandom;
    @(negedge clk);
    frame[1] = 1'b0; irdy[1] = 1'b1; ad[1] = 32'h0000_1000; cbe[1] = 4'b0111;
    @(negedge clk);
    irdy[1] = 1'b0; ad[1] = d; cbe[1] = 4'h0;
    cyc = 0;
    while (trdy[1] !== 1'b0 && cyc < 20) begin
      @(negedge clk); cyc++;
    end
    checks++;
    if (cyc >= 20) begin
      errors++; $display("FAIL rst_mid_wait s1 trdy got %b want 0", trdy[1]);
    end
    @(negedge clk);
    ad[1] = $urandom;
    rst[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (trdy[1] !== 1'b1 || devsel[1] !== 1'b1 || stop[1] !== 1'b1 || ad_oe[1] !== 1'b0) begin
      errors++; $display("FAIL rst_mid s1 trdy/devsel/stop/oe got %b%b%b%b want 1110",
                         trdy[1], devsel[1], stop[1], ad_oe[1]);
    end
    rst[1] = 1'b0; frame[1] = 1'b1; irdy[1] = 1'b1;
    for (int i = 0; i < 16; i++) ref_mem[1][i] = '0;
    read_all(1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_byte_enables();
    test_burst_waits();
    test_disconnect();
    test_miss();
    test_random();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
